// File: rtl/name_reveal_pkg.sv
// Shared constants and message bitmap for the name_reveal column-scanned LED matrix.
// Bit i of each column pattern drives row i; entries past the message are blank.
package name_reveal_pkg;

  localparam int unsigned COL_W     = 4;
  localparam int unsigned ROW_W     = 16;
  localparam int unsigned MSG_DEPTH = 256;

  typedef logic [ROW_W-1:0] row_t;

  localparam row_t MSG_BITMAP [MSG_DEPTH] = '{
    0:  16'h0001, 1:  16'h8003, 2:  16'hFFFF, 3:  16'hFFFE,
    4:  16'h001C, 5:  16'h0038, 6:  16'h0070, 7:  16'h00E0,
    8:  16'h01C0, 9:  16'h0380, 10: 16'h0700, 11: 16'h0E00,
    12: 16'h7FFF, 13: 16'hFFF8, 14: 16'h8000, 15: 16'h0002,
    16: 16'h0004, 17: 16'hF800, 18: 16'hFF00, 19: 16'h1FE0,
    20: 16'h18F8, 21: 16'h183E, 22: 16'h180F, 23: 16'h1803,
    24: 16'h1807, 25: 16'h181E, 26: 16'h18F0, 27: 16'h1FC0,
    28: 16'hFE00, 29: 16'hF000, 30: 16'h8008, 31: 16'h0010,
    32: 16'h0020, 33: 16'hFFFC, 34: 16'hFFF0, 35: 16'h003E,
    36: 16'h00F8, 37: 16'h03E0, 38: 16'h0F80, 39: 16'h3E00,
    40: 16'h3C00, 41: 16'h0F00, 42: 16'h03C0, 43: 16'h00F0,
    44: 16'hFFF6, 45: 16'hFFF4, 46: 16'h0040, 47: 16'h0080,
    48: 16'h0100, 49: 16'hFFFD, 50: 16'hFFFB, 51: 16'hC183,
    52: 16'hC185, 53: 16'hC189, 54: 16'hC191, 55: 16'hC1A1,
    56: 16'hC1C1, 57: 16'hC181, 58: 16'hC081, 59: 16'hC003,
    60: 16'hE007, 61: 16'h6006, 62: 16'h0200, 63: 16'h0400,
    default: 16'h0000
  };

  // offset < cols and column < 16 <= cols, so one conditional subtract reduces the sum.
  function automatic logic [7:0] wrap_col(input logic [8:0] sum, input int unsigned cols);
    logic [8:0] r;
    r = (sum >= 9'(cols)) ? sum - 9'(cols) : sum;
    return r[7:0];
  endfunction

endpackage

// File: rtl/name_rom.sv
// Combinational column lookup into the message bitmap.
module name_rom
  import name_reveal_pkg::*;
(
  input  logic [7:0]       idx,
  output logic [ROW_W-1:0] pattern
);

  always_comb begin
    pattern = MSG_BITMAP[idx];
  end

endmodule

// File: rtl/name_reveal.sv
// Column-scanned 16x16 matrix driver showing a message window, optionally scrolling.
// Scrolling is compiled in with NAME_REVEAL_SCROLL_EN; otherwise columns 0..15 are shown statically.
module name_reveal
  import name_reveal_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned FRAMES_PER_STEP = 8,
  parameter int unsigned MSG_COLS        = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [COL_W-1:0] keyc,
  output logic [ROW_W-1:0] keyr
);

  logic [15:0]      scan_cnt;
  logic             scan_wrap;
  logic [COL_W-1:0] col_next;
  logic [7:0]       off_next;
  logic [7:0]       rom_idx;
  logic [ROW_W-1:0] rom_row;

  always_comb begin
    scan_wrap = (scan_cnt == 16'(SCAN_DIV - 1));
    col_next  = scan_wrap ? keyc + 4'd1 : keyc;
  end

`ifdef NAME_REVEAL_SCROLL_EN
  logic [7:0] frame_cnt;
  logic [7:0] offset;
  logic       frame_end;
  logic       step;

  always_comb begin
    frame_end = scan_wrap && (keyc == 4'd15);
    step      = frame_end && (frame_cnt == 8'(FRAMES_PER_STEP - 1));
    off_next  = offset;
    if (step) begin
      off_next = (offset == 8'(MSG_COLS - 1)) ? '0 : offset + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      offset    <= '0;
    end else begin
      offset <= off_next;
      if (frame_end) begin
        frame_cnt <= step ? '0 : frame_cnt + 8'd1;
      end
    end
  end
`else
  always_comb begin
    off_next = '0;
  end
`endif

  // The ROM is addressed with next-state column/offset so keyr registers alongside keyc.
  always_comb begin
    rom_idx = rst_n ? wrap_col({1'b0, off_next} + 9'(col_next), MSG_COLS) : '0;
  end

  name_rom u_rom (
    .idx     (rom_idx),
    .pattern (rom_row)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      keyc     <= '0;
      keyr     <= rom_row;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 16'd1;
      keyc     <= col_next;
      keyr     <= rom_row;
    end
  end

endmodule

// File: tb/tb_name_reveal.sv
// Self-checking bench for name_reveal: fixed-time vectors, mid-scan reset and randomized resets
// against a time-based reference model (works with NAME_REVEAL_SCROLL_EN defined or not).
module tb_name_reveal;
  import name_reveal_pkg::*;

  localparam int unsigned SD  = 2;
  localparam int unsigned FPS = 2;
  localparam int unsigned MC  = 64;

  logic       clk;
  logic       rst_n;
  logic [3:0] keyc;
  logic [15:0] keyr;

  int unsigned t;
  int          n_cmp;
  int          n_bad;

  typedef struct {
    string       name;
    int unsigned t;
    logic [3:0]  keyc;
    logic [15:0] keyr;
  } vec_t;

  vec_t vecs [$];

  name_reveal #(
    .SCAN_DIV        (SD),
    .FRAMES_PER_STEP (FPS),
    .MSG_COLS        (MC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .keyc  (keyc),
    .keyr  (keyr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: everything follows from the number of clocks since reset release.
  function automatic logic [3:0] m_keyc(input int unsigned tt);
    return 4'((tt / SD) % 16);
  endfunction

  function automatic logic [15:0] m_keyr(input int unsigned tt);
    int unsigned off;
`ifdef NAME_REVEAL_SCROLL_EN
    off = ((tt / (16 * SD)) / FPS) % MC;
`else
    off = 0;
`endif
    return MSG_BITMAP[(off + (tt / SD) % 16) % MC];
  endfunction

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
    end
  endtask

  task automatic check_model();
    cmp("model_keyc", {12'h0, keyc}, {12'h0, m_keyc(t)});
    cmp("model_keyr", keyr, m_keyr(t));
  endtask

  task automatic step();
    @(negedge clk);
    t++;
    check_model();
  endtask

  task automatic do_reset(input int unsigned n);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    check_model();
  endtask

  function automatic logic [15:0] bm(input int unsigned i);
    return MSG_BITMAP[i];
  endfunction

  initial begin
    logic found;
    int unsigned vi;
    n_cmp = 0;
    n_bad = 0;
    t     = 0;
    rst_n = 1'b0;

    vecs.push_back('{"rst_hold0",  0,    4'd0,  bm(0)});
    vecs.push_back('{"rst_hold1",  1,    4'd0,  bm(0)});
    vecs.push_back('{"first_step", 2,    4'd1,  bm(1)});
    vecs.push_back('{"col1_hold",  3,    4'd1,  bm(1)});
    vecs.push_back('{"col15",      31,   4'd15, bm(15)});
    vecs.push_back('{"sweep_wrap", 32,   4'd0,  bm(0)});
    vecs.push_back('{"frame1_end", 63,   4'd15, bm(15)});
`ifdef NAME_REVEAL_SCROLL_EN
    vecs.push_back('{"offset1",    64,   4'd0,  bm(1)});
    vecs.push_back('{"offset1_h",  65,   4'd0,  bm(1)});
    vecs.push_back('{"offset1_c1", 66,   4'd1,  bm(2)});
    vecs.push_back('{"off60_c5",   3850, 4'd5,  bm(1)});
    vecs.push_back('{"off63_c0",   4032, 4'd0,  bm(63)});
    vecs.push_back('{"off63_c1",   4034, 4'd1,  bm(0)});
    vecs.push_back('{"off_wrap",   4096, 4'd0,  bm(0)});
`else
    vecs.push_back('{"static64",   64,   4'd0,  bm(0)});
    vecs.push_back('{"static65",   65,   4'd0,  bm(0)});
    vecs.push_back('{"static66",   66,   4'd1,  bm(1)});
    vecs.push_back('{"static_c5",  3850, 4'd5,  bm(5)});
    vecs.push_back('{"static_c0",  4032, 4'd0,  bm(0)});
    vecs.push_back('{"static_c1",  4034, 4'd1,  bm(1)});
    vecs.push_back('{"static_end", 4096, 4'd0,  bm(0)});
`endif

    // Reset held 3 cycles, then one long run hitting every table entry in time order.
    do_reset(3);
    vi = 0;
    while (vi < vecs.size() && vecs[vi].t == t) begin
      cmp({vecs[vi].name, "_keyc"}, {12'h0, keyc}, {12'h0, vecs[vi].keyc});
      cmp({vecs[vi].name, "_keyr"}, keyr, vecs[vi].keyr);
      vi++;
    end
    while (t < 4100) begin
      step();
      while (vi < vecs.size() && vecs[vi].t == t) begin
        cmp({vecs[vi].name, "_keyc"}, {12'h0, keyc}, {12'h0, vecs[vi].keyc});
        cmp({vecs[vi].name, "_keyr"}, keyr, vecs[vi].keyr);
        vi++;
      end
    end

    // One-cycle reset pulse while column 9 is active.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (keyc == 4'd9) found = 1'b1;
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_keyc9: got no keyc=9 within 40 cycles, required one");
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    cmp("midrst_keyc", {12'h0, keyc}, 16'h0000);
    cmp("midrst_keyr", keyr, bm(0));
    repeat (140) step();

    // Randomized reset points and lengths; the model restarts from t=0 each time.
    for (int k = 0; k < 25; k++) begin
      int unsigned run;
      run = $urandom_range(0, 300);
      repeat (run) step();
      do_reset($urandom_range(1, 3));
    end
    repeat (200) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/name_reveal.md
NAME_REVEAL -- requirements
Module: name_reveal

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles each column is held; legal range 1..65535.
REQ-002 Parameter FRAMES_PER_STEP, default 8: full 16-column frames per scroll step; legal range 1..255.
REQ-003 Parameter MSG_COLS, default 64: message length in columns (four 16x16 glyphs); legal range 16..256.
REQ-004 clk  input  1: single clock; all logic rising-edge triggered.
REQ-005 rst_n  input  1: reset, synchronous, active-low.
REQ-006 keyc  output  4: binary index of the active matrix column, 0..15.
REQ-007 keyr  output  16: row pattern of the active column; bit i=1 lights row i (active-high).

Function
REQ-008 Internal scan counter runs 0..SCAN_DIV-1 and wraps to 0.
REQ-009 On each scan-counter wrap, keyc SHALL increment by 1; 15 wraps to 0.
REQ-010 Each keyc value SHALL be held for exactly SCAN_DIV clk cycles; the full column sweep takes 16*SCAN_DIV cycles.
REQ-011 A frame counter runs 0..FRAMES_PER_STEP-1; it advances on each keyc transition from 15 to 0.
REQ-012 When the frame counter wraps, the scroll offset SHALL increment; MSG_COLS-1 wraps to 0.
REQ-013 keyr SHALL equal MSG_BITMAP[(offset + keyc) mod MSG_COLS] for the current keyc and offset values.
REQ-014 keyr and keyc are registered and SHALL change on the same clk edge, never one cycle apart.
REQ-015 Offset changes take effect only at a frame boundary (keyc=0), never mid-frame.
REQ-016 Column index arithmetic uses 8 bits modulo MSG_COLS; there is no out-of-range ROM access for any MSG_COLS.
REQ-017 With SCAN_DIV=1, keyc SHALL change on every clk edge.

Reset
REQ-018 When rst_n=0 at a clk edge:
- keyc=0, keyr=MSG_BITMAP[0].
- Scan counter, frame counter and offset are all 0.
REQ-019 Reset asserted mid-frame or mid-column SHALL abort the scan immediately, with no partial-hold carry-over.
REQ-020 The first column after reset release SHALL be held a full SCAN_DIV cycles.

Configuration
REQ-021 Macro NAME_REVEAL_SCROLL_EN:
- Defined: scrolling per REQ-011..REQ-015.
- Undefined: offset is constantly 0 and the frame counter is omitted; the display statically shows columns 0..15 of the message.

Structure
REQ-022 Package name_reveal_pkg holds:
- MSG_BITMAP: constant array of 256 x 16-bit column patterns; entries beyond MSG_COLS are 0.
- Column and row width constants (4 and 16).
REQ-023 One sub-module, name_rom: combinational lookup mapping an 8-bit column index to a 16-bit pattern from MSG_BITMAP.

Verification (SCAN_DIV=2, FRAMES_PER_STEP=2, NAME_REVEAL_SCROLL_EN defined unless noted)
REQ-024 Reset held 3 cycles then released -> keyc=0 and keyr=MSG_BITMAP[0] for 2 cycles, then keyc=1 and keyr=MSG_BITMAP[1].
REQ-025 Run 32 cycles after reset -> keyc walks 0..15 (2 cycles each) and returns to 0; offset stays 0.
REQ-026 Run 64 cycles after reset -> keyc=0 and keyr=MSG_BITMAP[1], i.e. offset=1.
REQ-027 Run 64*MSG_COLS cycles after reset (MSG_COLS=64) -> offset wraps to 0 and keyr=MSG_BITMAP[0]. At offset 60, keyc=5 shows MSG_BITMAP[1].
REQ-028 rst_n pulsed low one cycle while keyc=9 -> next edge gives keyc=0 and keyr=MSG_BITMAP[0], and all counters are cleared.
REQ-029 NAME_REVEAL_SCROLL_EN undefined, run 1000 cycles -> keyr always equals MSG_BITMAP[keyc].
